// File: rtl/cache_bank_arbiter.sv
// Two-port (fill/core) arbiter with a one-entry registered stage toward a cache bank.
// Optional perf counters: define CACHE_BANK_ARB_PERF_EN.
module cache_bank_arbiter #(
  parameter int PAYLOAD_W    = 315,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_valid,
  input  logic [PAYLOAD_W-1:0] f_payload,
  output logic                 f_ready,
  input  logic                 c_valid,
  input  logic [PAYLOAD_W-1:0] c_payload,
  output logic                 c_ready,
  output logic                 bank_valid,
  output logic [PAYLOAD_W-1:0] bank_payload,
  output logic                 bank_fromBUS,
  input  logic                 bank_ready,
  output logic                 starve_active
`ifdef CACHE_BANK_ARB_PERF_EN
  ,
  output logic [15:0]          perf_f_grants,
  output logic [15:0]          perf_c_grants,
  output logic [15:0]          perf_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 frombus_q, frombus_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 load, starve, grant_f, grant_c;

  always_comb begin
    load      = !valid_q || bank_ready;
    starve    = (cnt_q == LIMIT);
    // Fills win unless the core port has waited out its allowance.
    grant_f   = f_valid && !(c_valid && starve);
    grant_c   = c_valid && !grant_f;
    f_ready   = !rst && load && grant_f;
    c_ready   = !rst && load && grant_c;

    valid_d   = valid_q;
    payload_d = payload_q;
    frombus_d = frombus_q;
    cnt_d     = cnt_q;

    if (f_ready || c_ready) begin
      valid_d   = 1'b1;
      payload_d = f_ready ? f_payload : c_payload;
      frombus_d = f_ready;
    end else if (load) begin
      valid_d   = 1'b0;
    end

    if (!c_valid || c_ready) begin
      cnt_d = '0;
    end else if (f_ready && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      frombus_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      frombus_q <= frombus_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bank_valid    = valid_q;
  assign bank_payload  = payload_q;
  assign bank_fromBUS  = frombus_q;
  assign starve_active = starve;

`ifdef CACHE_BANK_ARB_PERF_EN
  logic [15:0] pf_q, pc_q, ps_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_q <= '0;
      pc_q <= '0;
      ps_q <= '0;
    end else begin
      if (f_ready && (pf_q != 16'hFFFF)) pf_q <= pf_q + 16'd1;
      if (c_ready && (pc_q != 16'hFFFF)) pc_q <= pc_q + 16'd1;
      if (valid_q && !bank_ready && (ps_q != 16'hFFFF)) ps_q <= ps_q + 16'd1;
    end
  end

  assign perf_f_grants     = pf_q;
  assign perf_c_grants     = pc_q;
  assign perf_stall_cycles = ps_q;
`endif

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Self-checking bench for cache_bank_arbiter: directed plan steps plus a random phase,
// all checked against a cycle-level behavioural model.
module tb_cache_bank_arbiter;
  localparam int W     = 315;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst, f_valid, c_valid, bank_ready;
  logic [W-1:0] f_payload, c_payload;
  logic         f_ready, c_ready, bank_valid, bank_fromBUS, starve_active;
  logic [W-1:0] bank_payload;
`ifdef CACHE_BANK_ARB_PERF_EN
  logic [15:0]  perf_f_grants, perf_c_grants, perf_stall_cycles;
`endif

  cache_bank_arbiter #(.PAYLOAD_W(W), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_payload(f_payload), .f_ready(f_ready),
    .c_valid(c_valid), .c_payload(c_payload), .c_ready(c_ready),
    .bank_valid(bank_valid), .bank_payload(bank_payload), .bank_fromBUS(bank_fromBUS),
    .bank_ready(bank_ready), .starve_active(starve_active)
`ifdef CACHE_BANK_ARB_PERF_EN
    , .perf_f_grants(perf_f_grants), .perf_c_grants(perf_c_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: what the bank should currently hold and how many F wins the core has sat through.
  bit           m_known = 0;
  bit           m_bv, m_fb;
  logic [W-1:0] m_pl;
  int           m_waited;
  int           m_pf, m_pc, m_ps;
  string        gs;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rpl();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic step(input bit r, input bit fv, input bit cv, input bit br,
                      input logic [W-1:0] fp, input logic [W-1:0] cp);
    bit ld, st, gf, gc, efr, ecr;
    rst = r; f_valid = fv; c_valid = cv; bank_ready = br;
    f_payload = fp; c_payload = cp;
    #1;
    ld  = !m_known || !m_bv || br;
    st  = m_waited >= LIMIT;
    gf  = fv && !(cv && st);
    gc  = cv && !gf;
    efr = !r && ld && gf;
    ecr = !r && ld && gc;
    chk("f_ready", W'(f_ready), W'(efr));
    chk("c_ready", W'(c_ready), W'(ecr));
    if (m_known) begin
      chk("bank_valid", W'(bank_valid), W'(m_bv));
      chk("bank_fromBUS", W'(bank_fromBUS), W'(m_fb));
      chk("bank_payload", bank_payload, m_pl);
      chk("starve_active", W'(starve_active), W'(st));
`ifdef CACHE_BANK_ARB_PERF_EN
      chk("perf_f", W'(perf_f_grants), W'(m_pf));
      chk("perf_c", W'(perf_c_grants), W'(m_pc));
      chk("perf_stall", W'(perf_stall_cycles), W'(m_ps));
`endif
    end
    gs = {gs, f_ready ? "F" : (c_ready ? "C" : "-")};
    if (r) begin
      m_known = 1; m_bv = 0; m_fb = 0; m_pl = '0; m_waited = 0;
      m_pf = 0; m_pc = 0; m_ps = 0;
    end else begin
      if (m_bv && !br && m_ps < 65535) m_ps++;
      if (efr && m_pf < 65535) m_pf++;
      if (ecr && m_pc < 65535) m_pc++;
      if (efr || ecr) begin
        m_bv = 1; m_fb = efr; m_pl = efr ? fp : cp;
      end else if (ld) begin
        m_bv = 0;
      end
      if (!cv || ecr) m_waited = 0;
      else if (efr) m_waited++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_seq(input string tag, input string exp);
    total++;
    assert (gs == exp) else begin
      bad++;
      $error("FAIL %s observed=%s expected=%s", tag, gs, exp);
    end
  endtask

  initial begin
    logic [W-1:0] ab, fnew;
    ab = W'(8'hAB);
    rst = 1; f_valid = 0; c_valid = 0; bank_ready = 0; f_payload = '0; c_payload = '0;
    @(posedge clk); #1;

    // Reset held two cycles with both requesters asserting.
    step(1, 1, 1, 1, W'(5), W'(6));
    step(1, 1, 1, 1, W'(5), W'(6));
    gs = "";
    step(0, 1, 1, 1, W'(5), W'(6));
    step(0, 0, 0, 1, '0, '0);
    chk_seq("first_grant_after_reset", "F-");

    // Core-only stream: back-to-back loads, no bubbles.
    step(0, 0, 1, 1, '0, W'(1));
    step(0, 0, 1, 1, '0, W'(2));
    step(0, 0, 1, 1, '0, W'(3));
    chk("lat_p1", bank_payload, W'(3));
    step(0, 0, 0, 1, '0, '0);

    // Starvation rotation with both ports saturated.
    gs = "";
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1, rpl(), rpl());
    chk_seq("starve_seq", "FFFFCFFFFC");

    // Backpressure holds the staged request and blocks both ports.
    step(0, 0, 0, 1, '0, '0);
    step(0, 1, 0, 1, ab, '0);
    fnew = rpl();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, fnew, rpl());
      chk("bp_hold", bank_payload, ab);
    end
    step(0, 1, 1, 1, fnew, rpl());
    chk("bp_release", bank_payload, fnew);
    step(0, 0, 0, 1, '0, '0);

    // Mid-operation reset after three F wins with core waiting.
    step(0, 0, 1, 1, '0, rpl());
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, rpl(), rpl());
    step(1, 1, 1, 0, rpl(), rpl());
    chk("midrst_valid", W'(bank_valid), W'(0));
    gs = "";
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, rpl(), rpl());
    chk_seq("midrst_seq", "FFFFC");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), rpl(), rpl());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_bank_arbiter.md
Name: cache_bank_arbiter

Overview:
- Two-requester arbiter with a registered output stage in front of one cache bank's request port.
- Port F carries line fills and writebacks returning from the bus deserializer. Port C carries core requests from the access queue.
- Fills normally take priority. A starvation counter guarantees port C forward progress.
- The registered output stage is a one-entry pipeline register toward the bank. It also drives the bank's fromBUS flag.

Parameters:
- PAYLOAD_W, 315, request payload width: vAddress 32 + pAddress 15 + data 128 + mask 128 + size 2 + {r,w,sw} 3 + PTC_ID 7.
- STARVE_LIMIT, 4, consecutive port-F grants allowed while port C is pending; range 1..15.
- CNT_W, 4, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_valid  in  1  fill request present.
- f_payload  in  PAYLOAD_W  fill request.
- f_ready  out  1  fill request accepted this cycle.
- c_valid  in  1  core request present (AQ not empty).
- c_payload  in  PAYLOAD_W  core request.
- c_ready  out  1  core request accepted this cycle (drives AQ read).
- bank_valid  out  1  registered request valid to the bank.
- bank_payload  out  PAYLOAD_W  registered request.
- bank_fromBUS  out  1  1 = bank_payload came from port F.
- bank_ready  in  1  bank consumes bank_payload this cycle (i.e. the bank's stall is low).
- starve_active  out  1  next grant is forced to port C.

Behaviour:
Reset:
- bank_valid=0, bank_payload=0, bank_fromBUS=0, starvation counter=0, starve_active=0.
- f_ready and c_ready are 0 while rst=1.
- Reset mid-operation drops any held request. Requesters must re-present it.

Load condition:
- load = !bank_valid | bank_ready.
- A grant happens only when load=1.

Arbitration, combinational from the current cycle:
- Only F valid → grant F.
- Only C valid → grant C.
- Both valid and starve_active=0 → grant F.
- Both valid and starve_active=1 → grant C.
- f_ready = load & grant_F; c_ready = load & grant_C. At most one is 1 per cycle.
- f_ready and c_ready never depend on the requester's own valid beyond the grant. Requesters must not make valid depend on ready.

Output register:
- On load with a grant: bank_payload ← winner payload; bank_fromBUS ← (winner==F); bank_valid ← 1.
- On load with no grant: bank_valid ← 0. Payload and fromBUS are held.
- On !load: all three outputs are held stable.
- Latency: a request accepted in cycle N appears on bank_valid in cycle N+1.
- Throughput: 1 request/cycle while bank_ready=1.

Starvation counter (cnt):
- On an F grant while c_valid=1: cnt ← cnt+1, saturating at STARVE_LIMIT.
- On a C grant: cnt ← 0.
- When c_valid=0: cnt ← 0.
- starve_active = (cnt == STARVE_LIMIT), registered state.

Boundary cases:
- bank_ready=0 with bank_valid=1: both readies are 0. Input valids may stay high. No payload change.
- Simultaneous bank_ready=1 and new grant: old request retires and the new one loads in the same edge. No bubble.
- c_valid dropping while starve_active=1: counter clears, and F wins on the next cycle.

Optional Feature:
- Macro: CACHE_BANK_ARB_PERF_EN.
- When defined, add three 16-bit outputs, all saturating and cleared by rst:
  - perf_f_grants: counts f_ready cycles.
  - perf_c_grants: counts c_ready cycles.
  - perf_stall_cycles: counts cycles with bank_valid=1 and bank_ready=0.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with f_valid=c_valid=1 → f_ready=c_ready=0, bank_valid=0, bank_payload=0. First cycle after rst=0 → f_ready=1, and bank_fromBUS=1 next cycle.
- Latency/throughput: c_valid=1 only, bank_ready=1, payloads 0x1,0x2,0x3 on successive cycles → bank_payload shows 0x1,0x2,0x3 on cycles N+1..N+3 with bank_fromBUS=0 and no bubbles.
- Starvation, STARVE_LIMIT=4: f_valid and c_valid held high, bank_ready=1 → grant sequence F,F,F,F,C,F,F,F,F,C. starve_active=1 exactly in the C-grant cycles.
- Backpressure: bank_valid=1 with payload 0xAB, bank_ready=0 for 3 cycles with both valids high → f_ready=c_ready=0 and bank_payload stays 0xAB. When bank_ready=1, the F payload loads in the same edge.
- Mid-operation reset: bank_valid=1 and cnt=3 when rst pulses one cycle → next cycle bank_valid=0, starve_active=0. With both valids high, 4 F grants occur before a C grant.
- CACHE_BANK_ARB_PERF_EN: 5 F grants, 2 C grants, 3 stall cycles → perf_f_grants=5, perf_c_grants=2, perf_stall_cycles=3. The counter reads 0xFFFF after saturation stimulus.
